aurora_bist_sequencer: RTL and testbench
========================================

AURORA_BIST_SEQUENCER -- requirements
Module: aurora_bist_sequencer

Interface
REQ-001 SHALL have parameter LINK_TIMEOUT, default 65535: max cycles waiting for channel_up.
REQ-002 SHALL have parameter LOCK_TIMEOUT, default 4095: max cycles waiting for checker lock.
REQ-003 SHALL have parameter RUN_CYCLES, default 512: measurement window after lock.
REQ-004 SHALL have parameter DRAIN_CYCLES, default 256: checker-only cycles after generator stops.
REQ-005 SHALL have parameter MIN_SAMPS, default 256: pass requires samps strictly greater than this.
REQ-006 clk  in  1  single clock; all logic on its rising edge.
REQ-007 rst_n  in  1  synchronous, active-low reset.
REQ-008 start  in  1  one-cycle request to begin a BIST run; ignored unless IDLE.
REQ-009 abort  in  1  level; forces the current run to end with code ABORTED.
REQ-010 cfg_rate  in  5  generator rate, captured on accepted start.
REQ-011 cfg_loopback  in  1  remote-loopback request, captured on accepted start.
REQ-012 channel_up  in  1  Aurora channel status.
REQ-013 bist_checker_locked  in  1  MAC checker lock.
REQ-014 bist_checker_samps  in  48  MAC checker sample count.
REQ-015 bist_checker_errors  in  48  MAC checker error count.
REQ-016 bist_gen_en, bist_checker_en, bist_loopback_en  out  1 each  MAC BIST controls.
REQ-017 bist_gen_rate  out  5  MAC generator rate.
REQ-018 busy  out  1  high in every state except IDLE.
REQ-019 done  out  1  one-cycle pulse at run end.
REQ-020 pass  out  1  result of last run, held until next accepted start.
REQ-021 fail_code  out  3  0 NONE, 1 LINK_TIMEOUT, 2 LOCK_TIMEOUT, 3 LINK_LOST, 4 LOW_SAMPS, 5 BIT_ERRORS, 6 ABORTED.
REQ-022 result_samps, result_errors  out  48 each  counts captured at end of RUN, held until next accepted start.

Function
REQ-023 States SHALL be IDLE, WAIT_LINK, WAIT_LOCK, RUN, DRAIN, FINISH; all outputs registered.
REQ-024 IDLE + start: next cycle enter WAIT_LINK; capture cfg_rate and cfg_loopback; clear pass, fail_code, results; bist_loopback_en set to captured value and held constant until FINISH exits.
REQ-025 WAIT_LINK: channel_up high -> WAIT_LOCK with bist_gen_en=1, bist_checker_en=1 and bist_gen_rate=captured rate, all asserted on the same cycle; counter over LINK_TIMEOUT -> FINISH, code 1.
REQ-026 WAIT_LOCK: bist_checker_locked high -> RUN, counter cleared; counter over LOCK_TIMEOUT -> DRAIN, code 2.
REQ-027 RUN SHALL last exactly RUN_CYCLES cycles; on its last cycle capture bist_checker_samps/errors into result_* and enter DRAIN.
REQ-028 channel_up low in WAIT_LOCK or RUN -> DRAIN next cycle, code 3; results captured from the inputs on that cycle.
REQ-029 DRAIN: bist_gen_en=0 on entry; bist_checker_en stays 1 for DRAIN_CYCLES, then 0 on entry to FINISH.
REQ-030 FINISH lasts one cycle: done=1; if code still 0, evaluate result_samps <= MIN_SAMPS -> 4, else result_errors != 0 -> 5, else pass=1; return to IDLE with bist_loopback_en=0.
REQ-031 abort in any non-IDLE state except FINISH: code 6 overrides any prior code; if gen/checker active go to DRAIN, else go to FINISH; abort in DRAIN or FINISH SHALL NOT shorten them.
REQ-032 First failure code recorded SHALL stick (except ABORTED override); pass=1 only when code=0.
REQ-033 start while busy SHALL be ignored with no side effect.
REQ-034 Timeout counters SHALL be 32-bit, saturating, cleared on every state entry; a timeout fires on the cycle the count equals the parameter.

Reset
REQ-035 rst_n low SHALL force IDLE next edge: all enables 0, bist_gen_rate 0, busy 0, done 0, pass 0, fail_code 0, results 0; reset mid-run drops generator and checker enables immediately, with no done pulse.

Verification
REQ-036 channel_up=1, locked 10 cycles after gen_en, samps=1000, errors=0 -> gen_en high 10+512 cycles, checker high 256 more, done pulse, pass=1, code 0, result_samps=1000.
REQ-037 channel_up held 0, start -> done after 65536 WAIT_LINK cycles, code 1, gen_en/checker_en never asserted.
REQ-038 locked never asserts -> gen off after 4096 cycles, checker off 256 later, code 2, pass=0.
REQ-039 errors=3 at RUN end -> code 5, result_errors=3; separate run with samps=256 -> code 4.
REQ-040 channel_up drops mid-RUN, then abort asserted in DRAIN -> code 6, DRAIN still 256 cycles; start pulsed while busy ignored; rst_n low mid-RUN -> all outputs 0 next cycle.

Source files
------------

// File: rtl/aurora_bist_sequencer.sv
// Aurora link BIST sequencer: brings up the link, waits for checker lock,
// runs a fixed measurement window, drains the checker, then grades the run.
module aurora_bist_sequencer #(
  parameter int unsigned LINK_TIMEOUT = 65535,
  parameter int unsigned LOCK_TIMEOUT = 4095,
  parameter int unsigned RUN_CYCLES   = 512,
  parameter int unsigned DRAIN_CYCLES = 256,
  parameter int unsigned MIN_SAMPS    = 256
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        start,
  input  logic        abort,
  input  logic [4:0]  cfg_rate,
  input  logic        cfg_loopback,
  input  logic        channel_up,
  input  logic        bist_checker_locked,
  input  logic [47:0] bist_checker_samps,
  input  logic [47:0] bist_checker_errors,
  output logic        bist_gen_en,
  output logic        bist_checker_en,
  output logic        bist_loopback_en,
  output logic [4:0]  bist_gen_rate,
  output logic        busy,
  output logic        done,
  output logic        pass,
  output logic [2:0]  fail_code,
  output logic [47:0] result_samps,
  output logic [47:0] result_errors
);

  typedef enum logic [2:0] {
    S_IDLE, S_WAIT_LINK, S_WAIT_LOCK, S_RUN, S_DRAIN, S_FINISH
  } state_t;

  typedef enum logic [2:0] {
    F_NONE = 3'd0, F_LINK_TIMEOUT = 3'd1, F_LOCK_TIMEOUT = 3'd2, F_LINK_LOST = 3'd3,
    F_LOW_SAMPS = 3'd4, F_BIT_ERRORS = 3'd5, F_ABORTED = 3'd6
  } fcode_t;

  localparam logic [31:0] LINK_TO    = 32'(LINK_TIMEOUT);
  localparam logic [31:0] LOCK_TO    = 32'(LOCK_TIMEOUT);
  localparam logic [31:0] RUN_LAST   = 32'(RUN_CYCLES - 1);
  localparam logic [31:0] DRAIN_LAST = 32'(DRAIN_CYCLES - 1);
  localparam logic [47:0] SAMP_MIN   = 48'(MIN_SAMPS);

  state_t      state_q, state_d;
  fcode_t      code_q, code_d, new_code;
  logic        capture;
  logic [31:0] cnt_q, cnt_d;
  logic [4:0]  rate_cap_q, rate_cap_d;
  logic        pass_q, pass_d;
  logic [47:0] res_samps_q, res_samps_d, res_err_q, res_err_d;
  logic        gen_en_q, gen_en_d, chk_en_q, chk_en_d, lb_q, lb_d;
  logic [4:0]  rate_out_q, rate_out_d;
  logic        busy_q, busy_d, done_q, done_d;
  logic        start_acc;

  // State register and all registered outputs
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q     <= S_IDLE;
      code_q      <= F_NONE;
      cnt_q       <= '0;
      rate_cap_q  <= '0;
      pass_q      <= 1'b0;
      res_samps_q <= '0;
      res_err_q   <= '0;
      gen_en_q    <= 1'b0;
      chk_en_q    <= 1'b0;
      lb_q        <= 1'b0;
      rate_out_q  <= '0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      code_q      <= code_d;
      cnt_q       <= cnt_d;
      rate_cap_q  <= rate_cap_d;
      pass_q      <= pass_d;
      res_samps_q <= res_samps_d;
      res_err_q   <= res_err_d;
      gen_en_q    <= gen_en_d;
      chk_en_q    <= chk_en_d;
      lb_q        <= lb_d;
      rate_out_q  <= rate_out_d;
      busy_q      <= busy_d;
      done_q      <= done_d;
    end
  end

  // Next state plus the failure event raised by this transition
  always_comb begin
    state_d  = state_q;
    new_code = F_NONE;
    capture  = 1'b0;
    unique case (state_q)
      S_IDLE:      if (start) state_d = S_WAIT_LINK;
      S_WAIT_LINK: begin
        if (abort) begin
          state_d = S_FINISH; new_code = F_ABORTED;
        end else if (channel_up) begin
          state_d = S_WAIT_LOCK;
        end else if (cnt_q == LINK_TO) begin
          state_d = S_FINISH; new_code = F_LINK_TIMEOUT;
        end
      end
      S_WAIT_LOCK: begin
        if (abort) begin
          state_d = S_DRAIN; new_code = F_ABORTED;
        end else if (!channel_up) begin
          state_d = S_DRAIN; new_code = F_LINK_LOST; capture = 1'b1;
        end else if (bist_checker_locked) begin
          state_d = S_RUN;
        end else if (cnt_q == LOCK_TO) begin
          state_d = S_DRAIN; new_code = F_LOCK_TIMEOUT;
        end
      end
      S_RUN: begin
        // any exit from the window snapshots the checker counts
        if (abort) begin
          state_d = S_DRAIN; new_code = F_ABORTED; capture = 1'b1;
        end else if (!channel_up) begin
          state_d = S_DRAIN; new_code = F_LINK_LOST; capture = 1'b1;
        end else if (cnt_q == RUN_LAST) begin
          state_d = S_DRAIN; capture = 1'b1;
        end
      end
      S_DRAIN: begin
        if (abort) new_code = F_ABORTED;
        if (cnt_q == DRAIN_LAST) state_d = S_FINISH;
      end
      S_FINISH:    state_d = S_IDLE;
      default:     state_d = S_IDLE;
    endcase
  end

  // Counter, result bookkeeping and output values for the next cycle
  always_comb begin
    start_acc   = (state_q == S_IDLE) && start;
    cnt_d       = (state_d != state_q) ? '0 : ((cnt_q == '1) ? cnt_q : cnt_q + 32'd1);
    rate_cap_d  = start_acc ? cfg_rate : rate_cap_q;
    code_d      = code_q;
    pass_d      = pass_q;
    res_samps_d = res_samps_q;
    res_err_d   = res_err_q;
    if (start_acc) begin
      code_d      = F_NONE;
      pass_d      = 1'b0;
      res_samps_d = '0;
      res_err_d   = '0;
    end else begin
      if (new_code == F_ABORTED) code_d = F_ABORTED;
      else if (new_code != F_NONE && code_q == F_NONE) code_d = new_code;
      if (capture) begin
        res_samps_d = bist_checker_samps;
        res_err_d   = bist_checker_errors;
      end
      // grading lands on the same edge as done so both are seen together
      if (state_d == S_FINISH && state_q != S_FINISH && code_d == F_NONE) begin
        if (res_samps_q <= SAMP_MIN)  code_d = F_LOW_SAMPS;
        else if (res_err_q != '0)     code_d = F_BIT_ERRORS;
        else                          pass_d = 1'b1;
      end
    end
    gen_en_d   = (state_d == S_WAIT_LOCK) || (state_d == S_RUN);
    chk_en_d   = gen_en_d || (state_d == S_DRAIN);
    rate_out_d = gen_en_d ? rate_cap_q : '0;
    lb_d       = start_acc ? cfg_loopback : ((state_d == S_IDLE) ? 1'b0 : lb_q);
    busy_d     = (state_d != S_IDLE);
    done_d     = (state_d == S_FINISH);
  end

  assign bist_gen_en      = gen_en_q;
  assign bist_checker_en  = chk_en_q;
  assign bist_loopback_en = lb_q;
  assign bist_gen_rate    = rate_out_q;
  assign busy             = busy_q;
  assign done             = done_q;
  assign pass             = pass_q;
  assign fail_code        = code_q;
  assign result_samps     = res_samps_q;
  assign result_errors    = res_err_q;

endmodule

// File: tb/tb_aurora_bist_sequencer.sv
// Randomized scenario bench for aurora_bist_sequencer with a run-level
// reference model that predicts phase boundaries, counts and the final grade.
module tb_aurora_bist_sequencer;

  localparam int LT = 200;
  localparam int LKT = 100;
  localparam int RC = 40;
  localparam int DC = 20;
  localparam int MS = 256;
  localparam int NEVER = 1 << 28;

  logic        clk = 1'b0;
  logic        rst_n, start, abort, cfg_loopback, channel_up, bist_checker_locked;
  logic [4:0]  cfg_rate;
  logic [47:0] bist_checker_samps, bist_checker_errors;
  logic        bist_gen_en, bist_checker_en, bist_loopback_en, busy, done, pass;
  logic [4:0]  bist_gen_rate;
  logic [2:0]  fail_code;
  logic [47:0] result_samps, result_errors;

  int vectors = 0;
  int miscompares = 0;

  aurora_bist_sequencer #(
    .LINK_TIMEOUT(LT), .LOCK_TIMEOUT(LKT), .RUN_CYCLES(RC),
    .DRAIN_CYCLES(DC), .MIN_SAMPS(MS)
  ) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .abort(abort),
    .cfg_rate(cfg_rate), .cfg_loopback(cfg_loopback), .channel_up(channel_up),
    .bist_checker_locked(bist_checker_locked),
    .bist_checker_samps(bist_checker_samps), .bist_checker_errors(bist_checker_errors),
    .bist_gen_en(bist_gen_en), .bist_checker_en(bist_checker_en),
    .bist_loopback_en(bist_loopback_en), .bist_gen_rate(bist_gen_rate),
    .busy(busy), .done(done), .pass(pass), .fail_code(fail_code),
    .result_samps(result_samps), .result_errors(result_errors)
  );

  always #5 clk = ~clk;

  typedef struct {
    int          up_at;  // channel_up rises on this cycle
    int          lk;     // locked high from this cycle
    int          dr;     // channel_up falls on this cycle
    int          ab;     // one-cycle abort on this cycle
    int          sb;     // stray start pulse while busy
    logic [47:0] base;
    bit          ramp;
    logic [47:0] err;
    logic [4:0]  rate;
    bit          lb;
  } scen_t;

  typedef struct {
    int          wl_start;   // first cycle with generator on, -1 if never
    int          drain_start;
    int          fin;        // cycle carrying done
    logic [2:0]  code;
    bit          pass;
    logic [47:0] rs, re;
  } exp_t;

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    vectors++;
    if (got !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic int mn(input int a, input int b);
    return (a < b) ? a : b;
  endfunction

  function automatic logic [47:0] samps_at(input scen_t s, input int j);
    return s.base + (s.ramp ? 48'(j) : 48'd0);
  endfunction

  // Predicts a whole run from the scenario's event times.
  function automatic void model(input scen_t s, output exp_t e);
    int t, en, ea, ed, el, et;
    e.wl_start = -1; e.drain_start = -1; e.code = 3'd0; e.pass = 1'b0;
    e.rs = '0; e.re = '0;
    ea = s.ab; et = LT;
    en = mn(ea, mn(s.up_at, et));
    if (en == ea) begin
      e.code = 3'd6; e.fin = en + 1;
    end else if (en == s.up_at) begin
      t = en + 1; e.wl_start = t;
      ea = (s.ab >= t) ? s.ab : NEVER;
      ed = s.dr;
      el = (s.lk > t) ? s.lk : t;
      et = t + LKT;
      en = mn(mn(ea, ed), mn(el, et));
      if (en == ea) e.code = 3'd6;
      else if (en == ed) begin
        e.code = 3'd3; e.rs = samps_at(s, en); e.re = s.err;
      end else if (en == el) begin
        t = en + 1;
        ea = (s.ab >= t) ? s.ab : NEVER;
        en = mn(mn(ea, s.dr), t + RC - 1);
        if (en == ea) e.code = 3'd6;
        else if (en == s.dr) e.code = 3'd3;
        e.rs = samps_at(s, en); e.re = s.err;
      end else e.code = 3'd2;
      e.drain_start = en + 1;
      if (s.ab >= e.drain_start && s.ab < e.drain_start + DC) e.code = 3'd6;
      e.fin = e.drain_start + DC;
    end else begin
      e.code = 3'd1; e.fin = en + 1;
    end
    if (e.code == 3'd0) begin
      if (e.rs <= 48'(MS))   e.code = 3'd4;
      else if (e.re != '0)   e.code = 3'd5;
      else                   e.pass = 1'b1;
    end
  endfunction

  task automatic idle_inputs();
    start = 1'b0; abort = 1'b0; channel_up = 1'b0; bist_checker_locked = 1'b0;
    bist_checker_samps = '0; bist_checker_errors = '0;
  endtask

  task automatic do_run(input string nm, input scen_t s_in);
    scen_t s;
    exp_t  e;
    int gen_cnt, chk_cnt, first_gen, done_cnt, done_at, rate_bad, busy_bad;
    s = s_in;
    model(s, e);
    if (s.sb < 0) s.sb = $urandom_range(0, e.fin);
    gen_cnt = 0; chk_cnt = 0; first_gen = -1; done_cnt = 0; done_at = -1;
    rate_bad = 0; busy_bad = 0;
    idle_inputs();
    start = 1'b1; cfg_rate = s.rate; cfg_loopback = s.lb;
    @(posedge clk); #1;
    for (int j = 0; j <= e.fin + 1; j++) begin
      channel_up          = (j >= s.up_at) && (j < s.dr);
      bist_checker_locked = (j >= s.lk);
      bist_checker_samps  = samps_at(s, j);
      bist_checker_errors = s.err;
      abort               = (j == s.ab);
      start               = (j == s.sb);
      cfg_rate            = 5'($urandom);
      cfg_loopback        = 1'($urandom);
      @(negedge clk);
      if (j == 0)
        check_eq({nm, ".cleared"}, {pass, fail_code, result_samps, result_errors}, '0);
      if (bist_gen_en) begin
        gen_cnt++;
        if (first_gen < 0) first_gen = j;
        if (bist_gen_rate != s.rate) rate_bad++;
      end else if (bist_gen_rate != 5'd0) rate_bad++;
      if (bist_checker_en) chk_cnt++;
      if (done) begin done_cnt++; done_at = j; end
      if (j <= e.fin && (busy !== 1'b1 || bist_loopback_en !== s.lb)) busy_bad++;
      if (j == e.fin) begin
        check_eq({nm, ".code"}, 64'(fail_code), 64'(e.code));
        check_eq({nm, ".pass"}, 64'(pass), 64'(e.pass));
        check_eq({nm, ".samps"}, 64'(result_samps), 64'(e.rs));
        check_eq({nm, ".errors"}, 64'(result_errors), 64'(e.re));
      end
      if (j == e.fin + 1)
        check_eq({nm, ".idle"},
                 {busy, bist_loopback_en, bist_gen_en, bist_checker_en, done, pass, fail_code},
                 {5'b0, e.pass, e.code});
      @(posedge clk); #1;
    end
    idle_inputs();
    check_eq({nm, ".first_gen"}, 64'(first_gen), 64'(e.wl_start));
    check_eq({nm, ".gen_cycles"}, 64'(gen_cnt),
             64'((e.wl_start < 0) ? 0 : e.drain_start - e.wl_start));
    check_eq({nm, ".chk_cycles"}, 64'(chk_cnt),
             64'((e.wl_start < 0) ? 0 : e.fin - e.wl_start));
    check_eq({nm, ".done_count"}, 64'(done_cnt), 64'd1);
    check_eq({nm, ".done_at"}, 64'(done_at), 64'(e.fin));
    check_eq({nm, ".rate"}, 64'(rate_bad), 64'd0);
    check_eq({nm, ".busy_lb"}, 64'(busy_bad), 64'd0);
  endtask

  function automatic scen_t mk(input int up_at, input int lk, input int dr, input int ab,
                               input logic [47:0] base, input bit ramp, input logic [47:0] err);
    scen_t s;
    s.up_at = up_at; s.lk = lk; s.dr = dr; s.ab = ab; s.sb = -1;
    s.base = base; s.ramp = ramp; s.err = err;
    s.rate = 5'($urandom); s.lb = 1'($urandom);
    return s;
  endfunction

  initial begin
    scen_t s;
    rst_n = 1'b0; cfg_rate = '0; cfg_loopback = 1'b0;
    idle_inputs();
    repeat (3) @(posedge clk);
    @(negedge clk);
    check_eq("reset.ctl",
             {bist_gen_en, bist_checker_en, bist_loopback_en, bist_gen_rate, busy, done, pass, fail_code}, '0);
    check_eq("reset.res", {result_samps, result_errors}, '0);
    @(posedge clk); #1;
    rst_n = 1'b1;
    @(posedge clk); #1;

    do_run("nominal",      mk(3, 13, NEVER, NEVER, 48'd1000, 1'b0, 48'd0));
    do_run("link_timeout", mk(NEVER, NEVER, NEVER, NEVER, 48'd1000, 1'b0, 48'd0));
    do_run("lock_timeout", mk(0, NEVER, NEVER, NEVER, 48'd1000, 1'b0, 48'd0));
    do_run("bit_errors",   mk(1, 5, NEVER, NEVER, 48'd1000, 1'b0, 48'd3));
    do_run("low_samps",    mk(1, 5, NEVER, NEVER, 48'd256, 1'b0, 48'd0));
    do_run("drop_abort",   mk(2, 3, 14, 20, 48'd300, 1'b1, 48'd0));
    do_run("abort_finish", mk(0, 0, NEVER, 1 + 1 + RC + DC, 48'd900, 1'b0, 48'd0));

    for (int r = 0; r < 40; r++) begin
      s.up_at = ($urandom_range(0, 5) == 0) ? int'($urandom_range(LT - 3, LT + 10))
                                            : int'($urandom_range(0, 30));
      s.lk    = $urandom_range(0, s.up_at + LKT + 8);
      s.dr    = ($urandom_range(0, 2) == 0) ? s.up_at + 1 + int'($urandom_range(0, 150)) : NEVER;
      s.ab    = ($urandom_range(0, 3) == 0) ? int'($urandom_range(0, 300)) : NEVER;
      s.sb    = -1;
      s.base  = 48'($urandom_range(0, 600));
      s.ramp  = 1'($urandom);
      s.err   = ($urandom_range(0, 2) == 0) ? 48'($urandom_range(1, 7)) : 48'd0;
      s.rate  = 5'($urandom);
      s.lb    = 1'($urandom);
      do_run($sformatf("rand%0d", r), s);
    end

    // reset while the measurement window is open
    start = 1'b1; cfg_rate = 5'd9; cfg_loopback = 1'b1;
    channel_up = 1'b1; bist_checker_locked = 1'b1; bist_checker_samps = 48'd500;
    @(posedge clk); #1;
    start = 1'b0;
    repeat (5) @(posedge clk);
    @(negedge clk);
    check_eq("midrun.gen_on", {bist_gen_en, bist_checker_en, busy}, 3'b111);
    @(posedge clk); #1;
    rst_n = 1'b0;
    @(negedge clk);
    check_eq("midrun.gen_on_pre", 64'(bist_gen_en), 64'd1);
    @(posedge clk); #1;
    check_eq("midrun.reset",
             {bist_gen_en, bist_checker_en, bist_loopback_en, bist_gen_rate, busy, done, pass, fail_code,
              result_samps, result_errors}, '0);
    @(posedge clk); #1;
    check_eq("midrun.no_done", 64'(done), 64'd0);
    rst_n = 1'b1;
    idle_inputs();
    repeat (2) @(posedge clk);
    @(negedge clk);
    check_eq("midrun.idle", {busy, done, bist_gen_en}, 3'b000);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
